musb_multdiv: RTL and testbench

- HI/LO multiply/divide unit in the EX stage, fed by the ID->EX pipeline register outputs (ex_data_rs, ex_data_rt and a decoded HI/LO operation).
- Multiplies run on a 2-cycle pipelined path; divides run on a 32-iteration restoring divider.
- Owns the architectural HI and LO registers.
- Raises a stall to the hazard logic when an EX instruction needs HI/LO while an operation is still in flight.

---
 rtl/musb_multdiv.sv | 139 +++++++++++++
 tb/tb_musb_multdiv.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/musb_multdiv.sv
// musb_multdiv: HI/LO multiply/divide unit with a 2-cycle multiply and a 32-step restoring divider.
// Define MUSB_MADD_EN to build MADD/MADDU/MSUB/MSUBU (ops 7-10); otherwise they decode as NOP.
module musb_multdiv #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ex_data_rs,
  input  logic [31:0] ex_data_rt,
  input  logic [3:0]  ex_hilo_op,
  input  logic        ex_hilo_read,
  input  logic        ex_enable,
  input  logic        ex_flush,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        hilo_stall
);
  typedef enum logic [2:0] {IDLE, MUL, ACC, DIV, DIV_FIX} state_t;
  localparam logic [3:0] OP_MULT = 4'd1;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_DIVU = 4'd4;
  localparam logic [3:0] OP_MTHI = 4'd5;
  localparam logic [3:0] OP_MTLO = 4'd6;
  localparam logic [4:0] LAST    = 5'(DIV_CYCLES - 1);
  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d, quo_q, quo_d, rem_q, rem_d, hi_q, hi_d, lo_q, lo_d;
  logic        sb_q, sb_d;
  logic [63:0] prod_q, prod_d;
  logic        op_valid, is_div, is_mt, mul_signed;
  logic [63:0] a_ext, b_ext, acc;
  logic [32:0] rem_sh, trial;
  logic [31:0] quo_fix, rem_fix;
`ifdef MUSB_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
  assign op_valid   = ex_hilo_op >= 4'd1 && ex_hilo_op <= 4'd10;
  assign mul_signed = op_q == OP_MULT || op_q == OP_MADD || op_q == OP_MSUB;
  assign acc = (op_q == OP_MADD || op_q == OP_MADDU) ? {hi_q, lo_q} + prod_q :
               (op_q == OP_MSUB || op_q == OP_MSUBU) ? {hi_q, lo_q} - prod_q : prod_q;
`else
  assign op_valid   = ex_hilo_op >= 4'd1 && ex_hilo_op <= 4'd6;
  assign mul_signed = op_q == OP_MULT;
  assign acc        = prod_q;
`endif
  assign is_div     = ex_hilo_op == OP_DIV || ex_hilo_op == OP_DIVU;
  assign is_mt      = ex_hilo_op == OP_MTHI || ex_hilo_op == OP_MTLO;
  assign a_ext      = {{32{mul_signed & a_q[31]}}, a_q};
  assign b_ext      = {{32{mul_signed & b_q[31]}}, b_q};
  assign rem_sh     = {rem_q, quo_q[31]};
  assign trial      = rem_sh - {1'b0, b_q};
  assign quo_fix    = (op_q == OP_DIV && (a_q[31] ^ sb_q)) ? -quo_q : quo_q;
  assign rem_fix    = (op_q == OP_DIV && a_q[31]) ? -rem_q : rem_q;
  assign hilo_stall = state_q != IDLE && (op_valid || ex_hilo_read);
  assign hi         = hi_q;
  assign lo         = lo_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    sb_d    = sb_q;
    prod_d  = prod_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (state_q != IDLE && ex_flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (ex_enable && !ex_flush && op_valid) begin
          op_d    = ex_hilo_op;
          a_d     = ex_data_rs;
          sb_d    = ex_data_rt[31];
          cnt_d   = '0;
          rem_d   = '0;
          b_d     = (ex_hilo_op == OP_DIV && ex_data_rt[31]) ? -ex_data_rt : ex_data_rt;
          quo_d   = (ex_hilo_op == OP_DIV && ex_data_rs[31]) ? -ex_data_rs : ex_data_rs;
          hi_d    = ex_hilo_op == OP_MTHI ? ex_data_rs : hi_q;
          lo_d    = ex_hilo_op == OP_MTLO ? ex_data_rs : lo_q;
          state_d = is_div ? DIV : is_mt ? IDLE : MUL;
        end
        MUL: begin
          prod_d  = a_ext * b_ext;
          state_d = ACC;
        end
        ACC: begin
          {hi_d, lo_d} = acc;
          state_d      = IDLE;
        end
        // Restoring step: keep the trial difference only when it did not borrow.
        DIV: begin
          rem_d   = trial[32] ? rem_sh[31:0] : trial[31:0];
          quo_d   = {quo_q[30:0], ~trial[32]};
          cnt_d   = cnt_q + 5'd1;
          state_d = cnt_q == LAST ? DIV_FIX : DIV;
        end
        DIV_FIX: begin
          hi_d    = b_q == '0 ? a_q : rem_fix;
          lo_d    = b_q == '0 ? '1 : quo_fix;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      sb_q    <= 1'b0;
      prod_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      sb_q    <= sb_d;
      prod_q  <= prod_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end
endmodule

// File: tb/tb_musb_multdiv.sv
// tb_musb_multdiv: table-driven check of musb_multdiv plus directed flush/busy/reset sequences.
module tb_musb_multdiv;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] ex_data_rs = '0;
  logic [31:0] ex_data_rt = '0;
  logic [3:0]  ex_hilo_op = '0;
  logic        ex_hilo_read = 1'b0;
  logic        ex_enable = 1'b1;
  logic        ex_flush = 1'b0;
  logic [31:0] hi, lo;
  logic        hilo_stall;
  int checks = 0;
  int failures = 0;
  musb_multdiv dut (
    .clk(clk), .rst(rst), .ex_data_rs(ex_data_rs), .ex_data_rt(ex_data_rt),
    .ex_hilo_op(ex_hilo_op), .ex_hilo_read(ex_hilo_read), .ex_enable(ex_enable),
    .ex_flush(ex_flush), .hi(hi), .lo(lo), .hilo_stall(hilo_stall)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
    int          stalls;
  } vec_t;
  vec_t v[18];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask
  task automatic apply(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt, output int n);
    ex_hilo_op = op;
    ex_data_rs = rs;
    ex_data_rt = rt;
    @(negedge clk);
    ex_hilo_op = 4'd0;
    ex_hilo_read = 1'b1;
    #1;
    n = 0;
    while (hilo_stall && n < 60) begin
      n++;
      @(negedge clk);
      #1;
    end
    ex_hilo_read = 1'b0;
  endtask
  initial begin
    int n, m;
    v[0]  = '{4'd1,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 2};
    v[1]  = '{4'd2,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 2};
    v[2]  = '{4'd1,  32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 2};
    v[3]  = '{4'd4,  32'd100,      32'd7,        32'd2,        32'd14,       33};
    v[4]  = '{4'd3,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33};
    v[5]  = '{4'd4,  32'h1234,     32'd0,        32'h1234,     32'hFFFFFFFF, 33};
    v[6]  = '{4'd3,  32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 33};
    v[7]  = '{4'd3,  32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 33};
    v[8]  = '{4'd3,  32'h80000000, 32'd0,        32'h80000000, 32'hFFFFFFFF, 33};
    v[9]  = '{4'd5,  32'h55,       32'd0,        32'h55,       32'hFFFFFFFF, 0};
    v[10] = '{4'd6,  32'hAB,       32'd0,        32'h55,       32'hAB,       0};
    v[11] = '{4'd4,  32'hFFFFFFFF, 32'd1,        32'h0,        32'hFFFFFFFF, 33};
    v[12] = '{4'd5,  32'd1,        32'd0,        32'd1,        32'hFFFFFFFF, 0};
    v[13] = '{4'd6,  32'd0,        32'd0,        32'd1,        32'd0,        0};
`ifdef MUSB_MADD_EN
    v[14] = '{4'd8,  32'hFFFFFFFF, 32'd2,        32'd2,        32'hFFFFFFFE, 2};
    v[15] = '{4'd10, 32'hFFFFFFFF, 32'd2,        32'd1,        32'd0,        2};
    v[16] = '{4'd9,  32'hFFFFFFFF, 32'd2,        32'd1,        32'd2,        2};
    v[17] = '{4'd7,  32'd3,        32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, 2};
`else
    v[14] = '{4'd8,  32'hFFFFFFFF, 32'd2,        32'd1,        32'd0,        0};
    v[15] = '{4'd10, 32'hFFFFFFFF, 32'd2,        32'd1,        32'd0,        0};
    v[16] = '{4'd9,  32'hFFFFFFFF, 32'd2,        32'd1,        32'd0,        0};
    v[17] = '{4'd7,  32'd3,        32'hFFFFFFFF, 32'd1,        32'd0,        0};
`endif
    ex_hilo_read = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    chk("reset_stall", {31'b0, hilo_stall}, 32'h0);
    ex_hilo_read = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 18; i++) begin
      apply(v[i].op, v[i].rs, v[i].rt, n);
      chk($sformatf("vec%0d_stall_cycles", i), 32'(n), 32'(v[i].stalls));
      chk($sformatf("vec%0d_hi", i), hi, v[i].hi);
      chk($sformatf("vec%0d_lo", i), lo, v[i].lo);
    end
    apply(4'd5, 32'hA, 32'd0, n);
    apply(4'd6, 32'hB, 32'd0, n);
    ex_hilo_op = 4'd3; ex_data_rs = 32'd100; ex_data_rt = 32'd7;
    @(negedge clk);
    ex_hilo_op = 4'd0;
    repeat (9) @(negedge clk);
    ex_hilo_read = 1'b1;
    #1;
    chk("div_busy_stall", {31'b0, hilo_stall}, 32'h1);
    ex_hilo_read = 1'b0;
    ex_flush = 1'b1;
    @(negedge clk);
    ex_flush = 1'b0;
    ex_hilo_read = 1'b1;
    #1;
    chk("div_flush_stall", {31'b0, hilo_stall}, 32'h0);
    chk("div_flush_hi", hi, 32'hA);
    chk("div_flush_lo", lo, 32'hB);
    ex_hilo_read = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    chk("div_flush_late_hi", hi, 32'hA);
    chk("div_flush_late_lo", lo, 32'hB);
    ex_hilo_op = 4'd2; ex_data_rs = 32'd2; ex_data_rt = 32'd3;
    @(negedge clk);
    ex_hilo_op = 4'd0;
    @(negedge clk);
    ex_flush = 1'b1;
    @(negedge clk);
    ex_flush = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("acc_flush_hi", hi, 32'hA);
    chk("acc_flush_lo", lo, 32'hB);
    ex_flush = 1'b1; ex_hilo_op = 4'd5; ex_data_rs = 32'h99;
    @(negedge clk);
    ex_flush = 1'b0; ex_hilo_op = 4'd0;
    #1;
    chk("idle_flush_blocks", hi, 32'hA);
    ex_enable = 1'b0; ex_hilo_op = 4'd6; ex_data_rs = 32'h99;
    @(negedge clk);
    ex_enable = 1'b1; ex_hilo_op = 4'd0;
    #1;
    chk("disable_blocks", lo, 32'hB);
    ex_hilo_op = 4'd4; ex_data_rs = 32'd100; ex_data_rt = 32'd7;
    @(negedge clk);
    ex_hilo_op = 4'd2; ex_data_rs = 32'd3; ex_data_rt = 32'd5;
    #1;
    chk("held_op_stall", {31'b0, hilo_stall}, 32'h1);
    n = 0;
    while (hilo_stall && n < 60) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk("held_div_stall_cycles", 32'(n), 32'd33);
    chk("held_div_hi", hi, 32'd2);
    chk("held_div_lo", lo, 32'd14);
    @(negedge clk);
    ex_hilo_op = 4'd0;
    ex_hilo_read = 1'b1;
    #1;
    m = 0;
    while (hilo_stall && m < 60) begin
      m++;
      @(negedge clk);
      #1;
    end
    ex_hilo_read = 1'b0;
    chk("held_mul_stall_cycles", 32'(m), 32'd2);
    chk("held_mul_hi", hi, 32'd0);
    chk("held_mul_lo", lo, 32'd15);
    ex_hilo_op = 4'd4; ex_data_rs = 32'd1; ex_data_rt = 32'd1;
    @(negedge clk);
    ex_hilo_op = 4'd7;
    #1;
`ifdef MUSB_MADD_EN
    chk("op7_busy_stall", {31'b0, hilo_stall}, 32'h1);
`else
    chk("op7_busy_stall", {31'b0, hilo_stall}, 32'h0);
`endif
    ex_hilo_op = 4'd11;
    #1;
    chk("op11_busy_stall", {31'b0, hilo_stall}, 32'h0);
    ex_hilo_op = 4'd0;
    ex_flush = 1'b1;
    @(negedge clk);
    ex_flush = 1'b0;
    #1;
    chk("op7_flush_lo", lo, 32'd15);
    apply(4'd5, 32'h77, 32'd0, n);
    ex_hilo_op = 4'd3; ex_data_rs = 32'd9; ex_data_rt = 32'd2;
    @(negedge clk);
    ex_hilo_op = 4'd0;
    repeat (4) @(negedge clk);
    ex_hilo_read = 1'b1;
    #1;
    chk("pre_reset_stall", {31'b0, hilo_stall}, 32'h1);
    #1;
    rst = 1'b0;
    #1;
    chk("async_reset_hi", hi, 32'h0);
    chk("async_reset_lo", lo, 32'h0);
    chk("async_reset_stall", {31'b0, hilo_stall}, 32'h0);
    ex_hilo_read = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    apply(4'd2, 32'd6, 32'd7, n);
    chk("post_reset_stall_cycles", 32'(n), 32'd2);
    chk("post_reset_hi", hi, 32'd0);
    chk("post_reset_lo", lo, 32'd42);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
